// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n
//   Round-robin, demand-actuated light controller for NUM_DIR approaches.
//   Each served approach runs GREEN -> YELLOW -> ALLRED. Green time is
//   bounded by GREEN_MIN/GREEN_MAX. With no competing demand the green
//   rests on the current approach. Approaches with no demand are skipped
//   when the next approach is chosen.
//
// Optional feature macro: EMERGENCY_PREEMPT_EN
//   When defined, adds emerg_req/emerg_dir. A valid request forces the
//   green of any other approach to end, and steers the next green to
//   emerg_dir. It holds that green while the request stays high.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   demand     in   [NUM_DIR]   vehicle present/waiting per approach
//   emerg_req  in   1           (EMERGENCY_PREEMPT_EN only)
//   emerg_dir  in   [DIR_W]     (EMERGENCY_PREEMPT_EN only)
//   lights     out  [3*NUM_DIR] {red,yellow,green} per approach
//   active_dir out  [DIR_W]     approach currently served
//   phase      out  [2]         0 GREEN, 1 YELLOW, 2 ALLRED
//   count      out  [CNT_W]     cycles elapsed in current phase
module traffic_ctrl_n #(
  parameter int NUM_DIR   = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 1,
  localparam int DIR_W    = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_DIR-1:0]     demand,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                   emerg_req,
  input  logic [DIR_W-1:0]       emerg_dir,
`endif
  output logic [3*NUM_DIR-1:0]   lights,
  output logic [DIR_W-1:0]       active_dir,
  output logic [1:0]             phase,
  output logic [CNT_W-1:0]       count
);

  localparam logic [1:0] PH_GREEN  = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_ALLRED = 2'd2;

  localparam logic [CNT_W-1:0] G_MIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] G_MAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_M1     = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1    = CNT_W'(ALLRED_T - 1);
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);

  logic [1:0]       phase_q, phase_d;
  logic [DIR_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             own_req;
  logic             other_req;
  logic             green_end;
  logic             green_hold;
  logic [DIR_W-1:0] next_dir;

  // Split demand into the served approach and everyone else. Loops compare
  // against constant indices so no variable bit-select is needed.
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    for (int j = 0; j < NUM_DIR; j++) begin
      if (DIR_W'(j) == active_q) own_req = demand[j];
      else                       other_req = other_req | demand[j];
    end
  end

  // Round-robin search starting one past the active approach. Falls back to
  // plain rotation when nobody is waiting. Wrap is explicit at NUM_DIR-1.
  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    next_dir = (active_q == LAST_DIR) ? '0 : active_q + 1'b1;
    for (int k = 1; k < NUM_DIR; k++) begin
      idx = int'(active_q) + k;
      if (idx >= NUM_DIR) idx = idx - NUM_DIR;
      for (int j = 0; j < NUM_DIR; j++) begin
        if (!found && (j == idx) && demand[j]) begin
          found    = 1'b1;
          next_dir = DIR_W'(j);
        end
      end
    end
`ifdef EMERGENCY_PREEMPT_EN
    if (emerg_req && (int'(emerg_dir) < NUM_DIR)) next_dir = emerg_dir;
`endif
  end

  // Green termination. A pending emergency overrides both the minimum-green
  // rule and the demand rule; on its own approach it simply holds.
  always_comb begin
    green_end  = other_req &&
                 ((count_q == G_MAX_M1) || ((count_q >= G_MIN_M1) && !own_req));
    green_hold = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    if (emerg_req && (int'(emerg_dir) < NUM_DIR)) begin
      green_end  = (emerg_dir != active_q);
      green_hold = (emerg_dir == active_q);
    end
`endif
  end

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    count_d  = count_q;
    case (phase_q)
      PH_GREEN: begin
        if (green_end && !green_hold) begin
          phase_d = PH_YELLOW;
          count_d = '0;
        end else if (count_q != G_MAX_M1) begin
          count_d = count_q + 1'b1;  // saturates: rest-in-green
        end
      end
      PH_YELLOW: begin
        if (count_q == Y_M1) begin
          phase_d = PH_ALLRED;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      PH_ALLRED: begin
        if (count_q == AR_M1) begin
          phase_d  = PH_GREEN;
          active_d = next_dir;
          count_d  = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to the reset state.
        phase_d  = PH_GREEN;
        active_d = '0;
        count_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_GREEN;
      active_q <= '0;
      count_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

  // Served approach shows the phase colour; all others, and every approach
  // during ALLRED (or an illegal phase), show red.
  for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_light
    assign lights[3*gi +: 3] =
      (active_q != DIR_W'(gi)) ? 3'b100 :
      (phase_q == PH_GREEN)    ? 3'b001 :
      (phase_q == PH_YELLOW)   ? 3'b010 : 3'b100;
  end

  assign active_dir = active_q;
  assign phase      = phase_q;
  assign count      = count_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
module tb_traffic_ctrl_n;

  localparam int N   = 4;
  localparam int CW  = 8;
  localparam int GMN = 4;
  localparam int GMX = 16;
  localparam int YT  = 4;
  localparam int ART = 1;
  localparam int DW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  demand = '0;
  logic [3*N-1:0] lights;
  logic [DW-1:0] active_dir;
  logic [1:0]    phase;
  logic [CW-1:0] count;
`ifdef EMERGENCY_PREEMPT_EN
  logic          emerg_req = 1'b0;
  logic [DW-1:0] emerg_dir = '0;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state (plain integers, spec-level rules)
  int m_ph  = 0;   // 0 green, 1 yellow, 2 allred
  int m_dir = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  traffic_ctrl_n #(
    .NUM_DIR(N), .CNT_W(CW), .GREEN_MIN(GMN), .GREEN_MAX(GMX),
    .YELLOW_T(YT), .ALLRED_T(ART)
  ) dut (
    .clk(clk),
    .reset(reset),
    .demand(demand),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req(emerg_req),
    .emerg_dir(emerg_dir),
`endif
    .lights(lights),
    .active_dir(active_dir),
    .phase(phase),
    .count(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3*N-1:0] model_lights(input int ph, input int dir);
    logic [3*N-1:0] l;
    for (int i = 0; i < N; i++) begin
      if (i == dir && ph == 0)      l[3*i +: 3] = 3'b001;
      else if (i == dir && ph == 1) l[3*i +: 3] = 3'b010;
      else                          l[3*i +: 3] = 3'b100;
    end
    return l;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    int order[$];
    int pick;
    bit other;
    if (reset) begin
      m_ph = 0; m_dir = 0; m_cnt = 0;
      return;
    end
    case (m_ph)
      0: begin
        other = 0;
        for (int j = 0; j < N; j++) if (j != m_dir && demand[j]) other = 1;
        if (other && (m_cnt == GMX-1 || (m_cnt >= GMN-1 && !demand[m_dir]))) begin
          m_ph = 1; m_cnt = 0;
        end else if (m_cnt < GMX-1) m_cnt++;
      end
      1: if (m_cnt == YT-1) begin m_ph = 2; m_cnt = 0; end else m_cnt++;
      default: begin
        if (m_cnt == ART-1) begin
          for (int k = 1; k < N; k++) order.push_back((m_dir + k) % N);
          pick = (m_dir + 1) % N;
          foreach (order[q]) if (demand[order[q]]) begin pick = order[q]; break; end
          m_ph = 0; m_cnt = 0; m_dir = pick;
        end else m_cnt++;
      end
    endcase
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("phase", 32'(phase), 32'(m_ph));
    check("active_dir", 32'(active_dir), 32'(m_dir));
    check("count", 32'(count), 32'(m_cnt));
    check("lights", 32'(lights), 32'(model_lights(m_ph, m_dir)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    // Reset state
    do_reset();
    check("reset_lights", 32'(lights), 32'h921);
    check("reset_count", 32'(count), 32'd0);

    // Full demand: 16 green, 4 yellow, 1 allred per approach, 84 per rotation
    demand = 4'hF;
    for (int s = 1; s <= 84; s++) begin
      step();
      if (s == 16) check("t1_yellow_lights", 32'(lights), 32'h922);
      if (s == 20) check("t1_allred_lights", 32'(lights), 32'h924);
      if (s == 21) check("t1_dir1_lights", 32'(lights), 32'h90C);
    end
    check("t1_back_dir0", 32'(active_dir), 32'd0);
    check("t1_back_green", 32'(phase), 32'd0);

    // Only approach 1 waiting: short green, then rest on approach 1
    do_reset();
    demand = 4'b0010;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (s == 4) check("t2_min_green_exit", 32'(phase), 32'd1);
    end
    check("t2_rest_dir", 32'(active_dir), 32'd1);
    check("t2_rest_count", 32'(count), 32'd15);

    // Skip approaches 1 and 2
    do_reset();
    demand = 4'b1001;
    for (int s = 1; s <= 21; s++) step();
    check("t3_skip_dir", 32'(active_dir), 32'd3);

    // No demand: rest in green, then a new request ends it at once
    do_reset();
    demand = '0;
    for (int s = 0; s < 100; s++) step();
    check("t4_rest_count", 32'(count), 32'd15);
    demand = 4'b0100;
    step();
    check("t4_yellow_now", 32'(phase), 32'd1);
    for (int s = 0; s < 5; s++) step();
    check("t4_dir2", 32'(active_dir), 32'd2);

    // Reset in the middle of yellow on approach 2
    do_reset();
    demand = 4'b0101;
    guard = 0;
    while (!(m_ph == 1 && m_dir == 2 && m_cnt == 2) && guard < 200) begin
      step();
      guard++;
    end
    check("t5_reached_yellow_dir2", 32'(guard < 200), 32'd1);
    do_reset();
    check("t5_phase", 32'(phase), 32'd0);
    check("t5_dir", 32'(active_dir), 32'd0);
    check("t5_lights", 32'(lights), 32'h921);

    // Randomized demand against the model, with occasional resets
    for (int s = 0; s < 3000; s++) begin
      if ($urandom_range(0, 3) == 0) demand = N'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
